// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg
//   Shared widths and constants for the operand-fetch stage.
//   REG_DATAWIDTH : GPR / operand data width
//   REGWIDTH      : GPR address width (32 registers)
//   WRITE_ENABLE  : active level of destination write-enable flags
//   ZERO_REG      : hard-wired zero register number
package operand_fetch_pkg;
  localparam int   REG_DATAWIDTH = 32;
  localparam int   REGWIDTH      = 5;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam int   ZERO_REG      = 0;
endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// fwd_mux
//   Combinational operand selector for one source register.
//   Priority: r0 -> 0, EX hit -> ex_data, MEM hit -> mem_data, else GPR.
//   src_addr            : source register number
//   gpr_data            : register file read data
//   ex_hit_en, ex_addr  : EX stage valid-and-writes flag / destination
//   ex_data             : EX stage result
//   mem_hit_en, mem_addr: MEM stage valid-and-writes flag / destination
//   mem_data            : MEM stage result
//   operand             : selected operand value
module fwd_mux
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = REG_DATAWIDTH,
  parameter int ADDR_W = REGWIDTH
) (
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] gpr_data,
  input  logic              ex_hit_en,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_hit_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] operand
);

  logic src_zero;
  assign src_zero = (src_addr == ADDR_W'(ZERO_REG));

  always_comb begin
    operand = gpr_data;
    // r0 is forced to zero even if a stage claims to write it
    if (src_zero)
      operand = '0;
    else if (ex_hit_en && (ex_addr == src_addr))
      operand = ex_data;
    else if (mem_hit_en && (mem_addr == src_addr))
      operand = mem_data;
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch
//   Operand stage between decode and EX: drives GPR read addresses,
//   forwards EX/MEM results, detects load-use hazards and holds the
//   ID/EX pipeline register.
//   Inputs : clk, reset (sync, active-high), id_* decoded instruction,
//            gpr_rd_data0/1, ex_alu_result, mem_en/mem_dst_we/mem_dst_addr/
//            mem_result, stall (downstream hold), flush (squash)
//   Outputs: gpr_rd_addr0/1 (combinational), id_stall (combinational),
//            ex_en/ex_dst_we/ex_is_load/ex_dst_addr/ex_opa/ex_opb/ex_pc
//            (registered ID/EX state)
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = REG_DATAWIDTH,
  parameter int ADDR_W = REGWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_en,
  input  logic [ADDR_W-1:0] id_ra_addr,
  input  logic [ADDR_W-1:0] id_rb_addr,
  input  logic              id_use_ra,
  input  logic              id_use_rb,
  input  logic              id_use_imm,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [ADDR_W-1:0] id_dst_addr,
  input  logic              id_dst_we,
  input  logic              id_is_load,
  input  logic [DATA_W-1:0] id_pc,
  output logic [ADDR_W-1:0] gpr_rd_addr0,
  output logic [ADDR_W-1:0] gpr_rd_addr1,
  input  logic [DATA_W-1:0] gpr_rd_data0,
  input  logic [DATA_W-1:0] gpr_rd_data1,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              mem_en,
  input  logic              mem_dst_we,
  input  logic [ADDR_W-1:0] mem_dst_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              stall,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_en,
  output logic              ex_dst_we,
  output logic              ex_is_load,
  output logic [ADDR_W-1:0] ex_dst_addr,
  output logic [DATA_W-1:0] ex_opa,
  output logic [DATA_W-1:0] ex_opb,
  output logic [DATA_W-1:0] ex_pc
);

  assign gpr_rd_addr0 = id_ra_addr;
  assign gpr_rd_addr1 = id_rb_addr;

  // WB writes land on negedge, so only EX and MEM need forwarding
  logic ex_fwd_en, mem_fwd_en;
  assign ex_fwd_en  = ex_en  & (ex_dst_we  == WRITE_ENABLE);
  assign mem_fwd_en = mem_en & (mem_dst_we == WRITE_ENABLE);

  logic [DATA_W-1:0] fwd_a, fwd_b, opb_sel;

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
    .src_addr  (id_ra_addr),
    .gpr_data  (gpr_rd_data0),
    .ex_hit_en (ex_fwd_en),
    .ex_addr   (ex_dst_addr),
    .ex_data   (ex_alu_result),
    .mem_hit_en(mem_fwd_en),
    .mem_addr  (mem_dst_addr),
    .mem_data  (mem_result),
    .operand   (fwd_a)
  );

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
    .src_addr  (id_rb_addr),
    .gpr_data  (gpr_rd_data1),
    .ex_hit_en (ex_fwd_en),
    .ex_addr   (ex_dst_addr),
    .ex_data   (ex_alu_result),
    .mem_hit_en(mem_fwd_en),
    .mem_addr  (mem_dst_addr),
    .mem_data  (mem_result),
    .operand   (fwd_b)
  );

  // Immediate replaces rb outright; no forwarding on that path
  assign opb_sel = id_use_imm ? id_imm : fwd_b;

  // Load data is not ready until MEM, so a consumer directly behind a
  // load waits one cycle and then picks the value up via MEM forwarding.
  logic load_use, ra_dep, rb_dep;
  assign ra_dep   = id_use_ra & (id_ra_addr == ex_dst_addr);
  assign rb_dep   = id_use_rb & ~id_use_imm & (id_rb_addr == ex_dst_addr);
  assign load_use = id_en & ex_en & ex_is_load & ex_dst_we &
                    (ex_dst_addr != ADDR_W'(ZERO_REG)) & (ra_dep | rb_dep);

  assign id_stall = stall | load_use;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_en       <= 1'b0;
      ex_dst_we   <= 1'b0;
      ex_is_load  <= 1'b0;
      ex_dst_addr <= '0;
      ex_opa      <= '0;
      ex_opb      <= '0;
      ex_pc       <= '0;
    end else if (flush) begin
      // squash wins over stall; data fields are left as-is
      ex_en      <= 1'b0;
      ex_dst_we  <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (load_use) begin
      ex_en      <= 1'b0;
      ex_dst_we  <= 1'b0;
      ex_is_load <= 1'b0;
    end else begin
      ex_en       <= id_en;
      ex_dst_we   <= id_en & id_dst_we;
      ex_is_load  <= id_en & id_is_load;
      ex_dst_addr <= id_dst_addr;
      ex_opa      <= fwd_a;
      ex_opb      <= opb_sel;
      ex_pc       <= id_pc;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_en, id_use_ra, id_use_rb, id_use_imm, id_dst_we, id_is_load;
  logic [AW-1:0] id_ra_addr, id_rb_addr, id_dst_addr, mem_dst_addr;
  logic [DW-1:0] id_imm, id_pc, gpr_rd_data0, gpr_rd_data1, ex_alu_result, mem_result;
  logic          mem_en, mem_dst_we, stall, flush;
  logic [AW-1:0] gpr_rd_addr0, gpr_rd_addr1, ex_dst_addr;
  logic          id_stall, ex_en, ex_dst_we, ex_is_load;
  logic [DW-1:0] ex_opa, ex_opb, ex_pc;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset(reset), .id_en(id_en),
    .id_ra_addr(id_ra_addr), .id_rb_addr(id_rb_addr),
    .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .id_use_imm(id_use_imm),
    .id_imm(id_imm), .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
    .id_is_load(id_is_load), .id_pc(id_pc),
    .gpr_rd_addr0(gpr_rd_addr0), .gpr_rd_addr1(gpr_rd_addr1),
    .gpr_rd_data0(gpr_rd_data0), .gpr_rd_data1(gpr_rd_data1),
    .ex_alu_result(ex_alu_result), .mem_en(mem_en), .mem_dst_we(mem_dst_we),
    .mem_dst_addr(mem_dst_addr), .mem_result(mem_result),
    .stall(stall), .flush(flush), .id_stall(id_stall),
    .ex_en(ex_en), .ex_dst_we(ex_dst_we), .ex_is_load(ex_is_load),
    .ex_dst_addr(ex_dst_addr), .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_pc(ex_pc)
  );

  typedef struct packed {
    logic          en;
    logic          we;
    logic          ld;
    logic [AW-1:0] dst;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [DW-1:0] pc;
  } ex_t;

  typedef struct {
    ex_t  v;
    logic chk_data;
    int   tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int step_no = 0;

  // monitor: compares the ID/EX register after each edge against the queue
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      ex_t  g;
      logic ok;
      e = q.pop_front();
      g = '{ex_en, ex_dst_we, ex_is_load, ex_dst_addr, ex_opa, ex_opb, ex_pc};
      ok = e.chk_data ? (g === e.v)
                      : ({g.en, g.we, g.ld} === {e.v.en, e.v.we, e.v.ld});
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL ex_state step %0d: got en=%b we=%b ld=%b dst=%0d opa=%h opb=%h pc=%h, exp en=%b we=%b ld=%b dst=%0d opa=%h opb=%h pc=%h (data checked=%b)",
                 e.tag, g.en, g.we, g.ld, g.dst, g.opa, g.opb, g.pc,
                 e.v.en, e.v.we, e.v.ld, e.v.dst, e.v.opa, e.v.opb, e.v.pc, e.chk_data);
      end
    end
  end

  task automatic clear_in();
    id_en = 0; id_use_ra = 0; id_use_rb = 0; id_use_imm = 0; id_dst_we = 0; id_is_load = 0;
    id_ra_addr = 0; id_rb_addr = 0; id_dst_addr = 0; id_imm = 0; id_pc = 0;
    gpr_rd_data0 = 0; gpr_rd_data1 = 0; ex_alu_result = 0;
    mem_en = 0; mem_dst_we = 0; mem_dst_addr = 0; mem_result = 0;
    stall = 0; flush = 0;
  endtask

  task automatic set_id(input logic en, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                        input logic [AW-1:0] dst, input logic we, input logic ld,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] pc);
    id_en = en; id_ra_addr = ra; id_rb_addr = rb; id_dst_addr = dst;
    id_dst_we = we; id_is_load = ld; gpr_rd_data0 = d0; gpr_rd_data1 = d1; id_pc = pc;
    id_use_ra = 1; id_use_rb = 1; id_use_imm = 0;
  endtask

  // inputs are already applied; check combinational outputs, then clock
  task automatic step(input ex_t v, input logic chk_data, input logic exp_stall);
    exp_t e;
    step_no++;
    #1;
    checks++;
    if (id_stall !== exp_stall) begin
      failures++;
      $display("FAIL id_stall step %0d: got %b exp %b", step_no, id_stall, exp_stall);
    end
    checks++;
    if ({gpr_rd_addr0, gpr_rd_addr1} !== {id_ra_addr, id_rb_addr}) begin
      failures++;
      $display("FAIL gpr_rd_addr step %0d: got %0d/%0d exp %0d/%0d",
               step_no, gpr_rd_addr0, gpr_rd_addr1, id_ra_addr, id_rb_addr);
    end
    @(posedge clk);
    e.v = v; e.chk_data = chk_data; e.tag = step_no;
    q.push_back(e);
    #2;
  endtask

  ex_t held;

  initial begin
    clear_in();
    @(posedge clk); #2;

    // reset with a valid instruction present
    reset = 1;
    set_id(1, 1, 2, 3, 1, 1, 32'h11, 32'h22, 32'h100);
    id_use_ra = 0; id_use_rb = 0;
    step('{0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0}, 1, 0);
    step('{0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0}, 1, 0);
    reset = 0;

    // add r3, r1, r2 enters EX
    set_id(1, 1, 2, 3, 1, 0, 32'h11, 32'h22, 32'h10);
    step('{1, 1, 0, 5'd3, 32'h11, 32'h22, 32'h10}, 1, 0);

    // add r4, r3, r2: ra forwarded from EX, rb=7 from GPR
    set_id(1, 3, 2, 4, 1, 0, 32'h99, 32'h7, 32'h14);
    ex_alu_result = 32'h55;
    step('{1, 1, 0, 5'd4, 32'h55, 32'h7, 32'h14}, 1, 0);

    // r5 producer
    set_id(1, 1, 1, 5, 1, 0, 32'h1, 32'h2, 32'h18);
    ex_alu_result = 32'h0;
    step('{1, 1, 0, 5'd5, 32'h1, 32'h2, 32'h18}, 1, 0);

    // r5 in both EX (0xA) and MEM (0xB): EX wins; rb=r0 reads 0; writes r0
    set_id(1, 5, 0, 0, 1, 0, 32'h77, 32'h0, 32'h1C);
    ex_alu_result = 32'hA;
    mem_en = 1; mem_dst_we = 1; mem_dst_addr = 5; mem_result = 32'hB;
    step('{1, 1, 0, 5'd0, 32'hA, 32'h0, 32'h1C}, 1, 0);

    // EX now targets r0: ra=r0 stays 0, rb=r5 falls back to MEM; issue load r6
    set_id(1, 0, 5, 6, 1, 1, 32'h0, 32'h66, 32'h20);
    step('{1, 1, 1, 5'd6, 32'h0, 32'hB, 32'h20}, 1, 0);

    // consumer of r6 right behind the load: one bubble
    mem_en = 0; mem_dst_we = 0; mem_dst_addr = 0; mem_result = 0;
    set_id(1, 6, 1, 7, 1, 0, 32'h5, 32'h9, 32'h24);
    ex_alu_result = 32'hBAD;
    step('{0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0}, 0, 1);

    // load now in MEM: operand taken from mem_result
    mem_en = 1; mem_dst_we = 1; mem_dst_addr = 6; mem_result = 32'h1234;
    step('{1, 1, 0, 5'd7, 32'h1234, 32'h9, 32'h24}, 1, 0);

    // load r6 again
    mem_en = 0; mem_dst_we = 0; mem_dst_addr = 0; mem_result = 0;
    ex_alu_result = 32'h0;
    set_id(1, 1, 0, 6, 1, 1, 32'h2, 32'h0, 32'h28);
    step('{1, 1, 1, 5'd6, 32'h2, 32'h0, 32'h28}, 1, 0);

    // immediate instead of rb=r6: no interlock, no forwarding on B
    set_id(1, 0, 6, 8, 1, 0, 32'h0, 32'h33, 32'h2C);
    id_use_ra = 0; id_use_imm = 1; id_imm = 32'hFFFF_FFF0;
    ex_alu_result = 32'hDEAD;
    step('{1, 1, 0, 5'd8, 32'h0, 32'hFFFF_FFF0, 32'h2C}, 1, 0);

    // flush with stall: squash wins
    id_use_imm = 0; id_imm = 0;
    flush = 1; stall = 1;
    step('{0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0}, 0, 1);
    flush = 0; stall = 0;

    // refill EX
    ex_alu_result = 32'h0;
    set_id(1, 2, 3, 9, 1, 0, 32'h42, 32'h43, 32'h30);
    held = '{1, 1, 0, 5'd9, 32'h42, 32'h43, 32'h30};
    step(held, 1, 0);

    // stall alone: ex_* frozen for 3 cycles while ID inputs change
    stall = 1;
    set_id(1, 4, 4, 10, 1, 1, 32'hFFFF_0000, 32'h0000_FFFF, 32'h99);
    step(held, 1, 1);
    step(held, 1, 1);
    step(held, 1, 1);
    stall = 0;

    // load r10
    set_id(1, 1, 1, 10, 1, 1, 32'h5, 32'h5, 32'h34);
    step('{1, 1, 1, 5'd10, 32'h5, 32'h5, 32'h34}, 1, 0);

    // invalid ID reading r10 behind the load: no interlock, captured as bubble
    set_id(0, 10, 0, 0, 1, 0, 32'h0, 32'h0, 32'h38);
    ex_alu_result = 32'h77;
    step('{0, 0, 0, 5'd0, 32'h77, 32'h0, 32'h38}, 1, 0);

    clear_in();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left exp 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
